// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT modulus defaults and Barrett constant helpers
package ntt_pkg;

  // Default coefficient width and modulus shared by mod_mul_pipe and mod_add
  localparam int NTT_WIDTH = 32;
  localparam int NTT_Q     = 3329;

  // Smallest n such that 2^n >= v (v >= 1)
  function automatic int ntt_clog2(input int v);
    int     r;
    longint x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Barrett shift: twice the modulus bit length so that any p < Q^2 reduces
  // to within two subtractions of the true residue
  function automatic int barrett_k(input int q);
    return 2 * ntt_clog2(q);
  endfunction

  // Barrett multiplier floor(2^K / Q)
  function automatic logic [63:0] barrett_mu(input int q);
    int k;
    k = barrett_k(q);
    return (64'd1 << k) / 64'(q);
  endfunction

endpackage

// File: rtl/barrett_reduce.sv
// rtl/barrett_reduce.sv - two-stage Barrett reduction of a double-width product
module barrett_reduce
  import ntt_pkg::*;
#(
  parameter int WIDTH = NTT_WIDTH,
  parameter int Q     = NTT_Q
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [2*WIDTH-1:0]   p_in,
  output logic [WIDTH-1:0]     r_out
);

  localparam int PW  = 2 * WIDTH;
  localparam int CL  = ntt_clog2(Q);
  localparam int K   = barrett_k(Q);
  // Q > 2^(CL-1) bounds MU below 2^(CL+1)
  localparam int MUW = CL + 1;
  localparam logic [MUW-1:0] MU  = MUW'(barrett_mu(Q));
  localparam logic [PW-1:0]  Q_P = PW'(Q);

  logic [PW-1:0]     p2_d, p2_q;
  logic [PW-1:0]     t2_d, t2_q;
  logic [PW+MUW-1:0] p_mu;
  logic [PW-1:0]     tq;
  logic [PW-1:0]     r0, r1, r2;
  logic [WIDTH-1:0]  r_d, r_q;

  // Stage 2 next state: keep the product and form the quotient estimate
  always_comb begin
    p_mu = {{MUW{1'b0}}, p_in} * {{PW{1'b0}}, MU};
    p2_d = p2_q;
    t2_d = t2_q;
    if (!stall) begin
      p2_d = p_in;
      t2_d = PW'(p_mu >> K);
    end
  end

  // Stage 3 next state: remainder estimate, then up to two corrections
  always_comb begin
    tq  = t2_q * Q_P;
    r0  = p2_q - tq;
    r1  = (r0 >= Q_P) ? (r0 - Q_P) : r0;
    r2  = (r1 >= Q_P) ? (r1 - Q_P) : r1;
    r_d = stall ? r_q : WIDTH'(r2);
  end

  // Stage 2/3 registers; all advance together under the shared stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_q <= '0;
      t2_q <= '0;
      r_q  <= '0;
    end else begin
      p2_q <= p2_d;
      t2_q <= t2_d;
      r_q  <= r_d;
    end
  end

  assign r_out = r_q;

endmodule

// File: rtl/mod_mul_pipe.sv
// rtl/mod_mul_pipe.sv - 3-stage (a*b) mod Q pipeline; MOD_MUL_RANGE_CHECK_EN adds sticky err_range
module mod_mul_pipe
  import ntt_pkg::*;
#(
  parameter int WIDTH = NTT_WIDTH,
  parameter int Q     = NTT_Q,
  parameter int TAG_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err_range
);

  localparam int PW = 2 * WIDTH;

  logic              adv;
  logic              v1_d, v1_q;
  logic [PW-1:0]     p1_d, p1_q;
  logic [TAG_W-1:0]  tag1_d, tag1_q;
  logic              v2_d, v2_q;
  logic [TAG_W-1:0]  tag2_d, tag2_q;
  logic              v3_d, v3_q;
  logic [TAG_W-1:0]  tag3_d, tag3_q;

  // Whole pipe moves when the output slot is empty or being drained
  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  // Stage 1 product plus valid/tag shift chain through all three stages
  always_comb begin
    v1_d   = v1_q;
    p1_d   = p1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    tag2_d = tag2_q;
    v3_d   = v3_q;
    tag3_d = tag3_q;
    if (adv) begin
      v1_d   = in_valid;
      p1_d   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      tag1_d = in_tag;
      v2_d   = v1_q;
      tag2_d = tag1_q;
      v3_d   = v2_q;
      tag3_d = tag2_q;
    end
  end

  // Stage 1 datapath and per-stage valid/tag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      p1_q   <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      tag2_q <= '0;
      v3_q   <= 1'b0;
      tag3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      p1_q   <= p1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      tag2_q <= tag2_d;
      v3_q   <= v3_d;
      tag3_q <= tag3_d;
    end
  end

  barrett_reduce #(
    .WIDTH (WIDTH),
    .Q     (Q)
  ) u_barrett (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (!adv),
    .p_in  (p1_q),
    .r_out (result)
  );

  assign out_valid = v3_q;
  assign out_tag   = tag3_q;

`ifdef MOD_MUL_RANGE_CHECK_EN
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  logic err_d, err_q;

  // Latch any accepted operand outside 0..Q-1; only reset clears it
  always_comb begin
    err_d = err_q;
    if (in_valid && adv && ((a >= Q_W) || (b >= Q_W))) begin
      err_d = 1'b1;
    end
  end

  // Sticky range error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_range = err_q;
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_mod_mul_pipe.sv
// tb/tb_mod_mul_pipe.sv - randomized scoreboard bench for mod_mul_pipe
module tb_mod_mul_pipe;

  localparam int WIDTH = 32;
  localparam int Q     = 3329;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             err_range;

  mod_mul_pipe #(
    .WIDTH (WIDTH),
    .Q     (Q),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [63:0] tag;
    int          cyc;
    bit          skip;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_out    = 0;

  bit acc       = 1'b0;
  bit hold_pend = 1'b0;
  bit lat_chk   = 1'b0;
  bit saw_stall = 1'b0;
  bit cur_skip  = 1'b0;
  bit use_force = 1'b0;
  logic [63:0]      force_exp = '0;
  logic [WIDTH-1:0] held_res = '0;
  logic [TAG_W-1:0] held_tag = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint px;
    px = longint'(x) * longint'(y);
    return 64'(px % Q);
  endfunction

  // One clock: sample at negedge+1, score outputs, record handshakes, advance to next negedge
  task automatic step();
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    if (in_valid && !in_ready) saw_stall = 1'b1;
    if (hold_pend) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_result", 64'(result), 64'(held_res));
      check_eq("hold_tag", 64'(out_tag), 64'(held_tag));
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check_eq("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        if (!e.skip) check_eq("result", 64'(result), e.res);
        check_eq("tag", 64'(out_tag), e.tag);
        if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'd3);
      end
    end
    hold_pend = out_valid && !out_ready;
    held_res  = result;
    held_tag  = out_tag;
    if (acc) begin
      e.res  = use_force ? force_exp : mulmod(a, b);
      e.tag  = 64'(in_tag);
      e.cyc  = cyc;
      e.skip = cur_skip;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    in_tag = t;
    do begin
      step();
      n++;
    end while (!acc && n < 50);
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    sb.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] dir_a [4];
  logic [WIDTH-1:0] dir_b [4];
  logic [63:0]      dir_r [4];

  initial begin
    int sent;
    int n0;
    dir_a = '{32'd3328, 32'd1234, 32'd0,    32'd1};
    dir_b = '{32'd3328, 32'd2345, 32'd3328, 32'd3328};
    dir_r = '{64'd1,    64'd829,  64'd0,    64'd3328};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_err_range", 64'(err_range), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed values with exact 3-cycle latency
    out_ready = 1'b1;
    lat_chk = 1'b1;
    use_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      force_exp = dir_r[i];
      send(dir_a[i], dir_b[i], TAG_W'(8'h10 + i));
      drain(10);
    end
    lat_chk = 1'b0;
    use_force = 1'b0;

    // Back-pressure: 4 back-to-back tags while out_ready is low for 5 cycles
    saw_stall = 1'b0;
    n0 = n_out;
    sent = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && (sent < 4 || sb.size() != 0); k++) begin
      out_ready = (k >= 5);
      if (sent < 4 && !in_valid) begin
        in_valid = 1'b1;
        a = WIDTH'($urandom_range(Q - 1));
        b = WIDTH'($urandom_range(Q - 1));
        in_tag = TAG_W'(sent + 1);
      end
      step();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("stall_sent", 64'(sent), 64'd4);
    check_eq("stall_in_ready_dropped", 64'(saw_stall), 64'd1);
    check_eq("stall_out_count", 64'(n_out - n0), 64'd4);

    // Reset with 3 transactions in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(WIDTH'($urandom_range(Q - 1)), WIDTH'($urandom_range(Q - 1)), TAG_W'(8'h20 + i));
    end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_result", 64'(result), 64'd0);
    check_eq("midrst_out_tag", 64'(out_tag), 64'd0);
    sb.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    n0 = n_out;
    repeat (6) step();
    check_eq("midrst_no_stale", 64'(n_out - n0), 64'd0);

    // Randomized traffic with random back-pressure
    sent = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 60000 && sent < 10000; k++) begin
      if (!in_valid && $urandom_range(9) < 8) begin
        in_valid = 1'b1;
        a = WIDTH'($urandom_range(Q - 1));
        b = WIDTH'($urandom_range(Q - 1));
        in_tag = TAG_W'($urandom);
      end
      out_ready = ($urandom_range(9) < 7);
      step();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("rand_sent", 64'(sent), 64'd10000);
    drain(50);
    check_eq("rand_err_range", 64'(err_range), 64'd0);

    // Out-of-range operand
    out_ready = 1'b1;
    cur_skip = 1'b1;
    send(WIDTH'(Q), 32'd5, 8'hAA);
    cur_skip = 1'b0;
`ifdef MOD_MUL_RANGE_CHECK_EN
    check_eq("range_set", 64'(err_range), 64'd1);
    drain(10);
    repeat (5) step();
    check_eq("range_sticky", 64'(err_range), 64'd1);
`else
    check_eq("range_off", 64'(err_range), 64'd0);
    drain(10);
    repeat (5) step();
    check_eq("range_off_later", 64'(err_range), 64'd0);
`endif
    pulse_reset();
    #1;
    check_eq("range_clear_on_reset", 64'(err_range), 64'd0);
    check_eq("final_out_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_mul_pipe.md
MOD_MUL_PIPE -- requirements
Module: mod_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: coefficient/twiddle bit width.
REQ-002 SHALL have parameter Q, default 3329: odd prime modulus, Q < 2^(WIDTH-1).
REQ-003 SHALL have parameter TAG_W, default 8: sideband tag width, passed through unchanged.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge; one clock, reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operands a, b and in_tag valid.
REQ-007 SHALL have port in_ready, output, 1: operands accepted when in_valid && in_ready.
REQ-008 SHALL have ports a and b, input, WIDTH each: operands, each in range 0..Q-1 (a = coefficient, b = twiddle).
REQ-009 SHALL have port in_tag, input, TAG_W: sideband tag.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: downstream (butterfly mod_add/mod_sub) accepts.
REQ-012 SHALL have port result, output, WIDTH: (a*b) mod Q, in range 0..Q-1.
REQ-013 SHALL have port out_tag, output, TAG_W: tag of the transaction presented on result.
REQ-014 SHALL have port err_range, output, 1: sticky operand range error flag (see Configuration).

Function
REQ-015 SHALL be a 3-stage pipeline: S1 registers p = a*b (2*WIDTH bits); S2 registers p and t = (p*MU) >> K; S3 registers r = p - t*Q, reduced by up to two conditional subtractions of Q.
REQ-016 SHALL use K = 2*ceil(log2(Q)) and MU = floor(2^K / Q), computed at elaboration (Q=3329: K=24, MU=5039).
REQ-017 SHALL have a latency of exactly 3 cycles from input handshake to out_valid when out_ready stays high.
REQ-018 SHALL sustain a throughput of one transaction per cycle when out_ready stays high.
REQ-019 SHALL use a global stall: all stages advance iff (!out_valid || out_ready), and in_ready SHALL equal that term combinationally.
REQ-020 SHALL keep result and out_tag stable while out_valid && !out_ready.
REQ-021 SHALL propagate bubbles: invalid stages carry valid=0, and the datapath registers of an invalid stage are don't-care.
REQ-022 SHALL NOT drop or duplicate any transaction, and SHALL preserve order.
REQ-023 SHALL carry intermediate arithmetic wide enough that no truncation occurs for operands < Q; only result is truncated to WIDTH.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_valid, result, out_tag and err_range to 0.
REQ-025 SHALL discard in-flight transactions on reset mid-operation, with no output after release until new inputs are accepted.
REQ-026 SHALL drive in_ready to 1 in the first cycle after reset release.

Configuration
REQ-027 SHALL, when MOD_MUL_RANGE_CHECK_EN is defined, set err_range sticky-high on any accepted transaction with a >= Q or b >= Q; the flag SHALL clear only on reset, and the result for such a transaction is undefined.
REQ-028 SHALL, when MOD_MUL_RANGE_CHECK_EN is not defined, tie err_range to 0 and contain no comparison logic.

Structure
REQ-029 SHALL take Q, WIDTH and the functions computing K and MU from shared package ntt_pkg, which is also used by mod_add.
REQ-030 SHALL instantiate exactly one sub-module, barrett_reduce, implementing S2–S3 with its own stall input, while S1 and valid/tag tracking stay in mod_mul_pipe.

Verification
REQ-031 SHALL be covered by a bench case: a=3328, b=3328, out_ready=1 -> result=1 exactly 3 cycles after the handshake.
REQ-032 SHALL be covered by a bench case: a=1234, b=2345 -> result=829; a=0, b=3328 -> result=0; a=1, b=3328 -> result=3328.
REQ-033 SHALL be covered by a bench case: 4 back-to-back inputs with tags 1..4 while out_ready is low for 5 cycles -> in_ready drops, the first result is held stable, and tags 1..4 then emerge in order with none lost.
REQ-034 SHALL be covered by a bench case: rst_n pulsed low with 3 transactions in flight -> out_valid=0 immediately and no stale output after release.
REQ-035 SHALL be covered by a bench case: 10,000 random operand pairs < Q with random out_ready -> every result matches (a*b)%Q in order.
REQ-036 SHALL be covered by a bench case: with MOD_MUL_RANGE_CHECK_EN defined, a=3329 accepted -> err_range=1 and it stays 1 until reset; without the macro, err_range stays 0.
